// File: rtl/alu_instr_decoder.sv
// Decode stage: 16-bit instruction -> func_t, register addresses and sign-extended immediate.
// Latency: 1 cycle from accept to output when the 2-entry buffer is empty, otherwise behind older entries.
// Backpressure: instr_ready_o depends on registered occupancy only; dec_ready_i never reaches it combinationally.

package simple_processor_pkg;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ADD     = 2'd0,
        SUB     = 2'd1,
        ADDI    = 2'd2,
        INVALID = 2'd3
    } func_t;
endpackage

module alu_instr_decoder
    import simple_processor_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int DATA_WIDTH  = simple_processor_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic                   flush_i,
    output func_t                  func_o,
    output logic [2:0]             rd_addr_o,
    output logic [2:0]             rs1_addr_o,
    output logic [2:0]             rs2_addr_o,
    output logic                   uses_rs2_o,
    output logic [5:0]             imm_o,
    output logic [DATA_WIDTH-1:0]  imm_ext_o,
    output logic                   dec_valid_o,
    input  logic                   dec_ready_i,
    output logic [CNT_WIDTH-1:0]   illegal_count_o
);

    // One fully decoded instruction as held in the buffer.
    typedef struct packed {
        func_t      func;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       uses_rs2;
        logic [5:0] imm;
    } dec_t;

    localparam dec_t EMPTY_REC = '{func: INVALID, rd: 3'd0, rs1: 3'd0, rs2: 3'd0,
                                   uses_rs2: 1'b0, imm: 6'd0};

    // Slot 0 is always the head; slot 1 is only meaningful when occupancy is 2.
    dec_t       r_slot0;
    dec_t       r_slot1;
    logic [1:0] r_occ;
    logic       r_rdy;
    logic [CNT_WIDTH-1:0] r_cnt;

    dec_t       w_dec;
    dec_t       w_head;
    dec_t       w_slot0_nxt;
    dec_t       w_slot1_nxt;
    logic [1:0] w_occ_nxt;
    logic [3:0] w_opcode;
    logic       w_acc;
    logic       w_pop;
    logic       w_illegal;

    assign w_opcode  = instr_i[15:12];
    assign w_acc     = instr_valid_i & r_rdy;
    assign w_pop     = (r_occ != 2'd0) & dec_ready_i;
    assign w_illegal = w_acc & (w_dec.func == INVALID);

    // Decode the incoming instruction ahead of the buffer registers.
    always_comb begin
        w_dec          = EMPTY_REC;
        w_dec.rd       = instr_i[11:9];
        w_dec.rs1      = instr_i[8:6];
        w_dec.imm      = instr_i[5:0];
        case (w_opcode)
            4'd0: begin
                w_dec.func     = ADD;
                w_dec.rs2      = instr_i[5:3];
                w_dec.uses_rs2 = 1'b1;
            end
            4'd1: begin
                w_dec.func     = SUB;
                w_dec.rs2      = instr_i[5:3];
                w_dec.uses_rs2 = 1'b1;
            end
            4'd2:    w_dec.func = ADDI;
            default: w_dec.func = INVALID;
        endcase
    end

    // Next buffer contents: flush empties it; a pop at occupancy 1 with an accept replaces the head.
    always_comb begin
        w_occ_nxt   = r_occ;
        w_slot0_nxt = r_slot0;
        w_slot1_nxt = r_slot1;
        if (flush_i) begin
            w_occ_nxt = 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (w_acc) begin
                        w_slot0_nxt = w_dec;
                        w_occ_nxt   = 2'd1;
                    end
                end
                2'd1: begin
                    if (w_acc && w_pop) begin
                        w_slot0_nxt = w_dec;
                    end else if (w_acc) begin
                        w_slot1_nxt = w_dec;
                        w_occ_nxt   = 2'd2;
                    end else if (w_pop) begin
                        w_occ_nxt   = 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        w_slot0_nxt = r_slot1;
                        w_occ_nxt   = 2'd1;
                    end
                end
                default: w_occ_nxt = 2'd0;
            endcase
        end
    end

    // Buffer state; ready is registered so it stays low through reset and rises on the first clock after.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_slot0 <= EMPTY_REC;
            r_slot1 <= EMPTY_REC;
            r_occ   <= 2'd0;
            r_rdy   <= 1'b0;
        end else begin
            r_slot0 <= w_slot0_nxt;
            r_slot1 <= w_slot1_nxt;
            r_occ   <= w_occ_nxt;
            r_rdy   <= (w_occ_nxt != 2'd2);
        end
    end

    // Saturating count of accepted INVALID opcodes; flushed instructions still count.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_cnt <= '0;
        end else if (w_illegal && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // An empty buffer presents a fixed INVALID/zero record instead of stale data.
    assign w_head = (r_occ != 2'd0) ? r_slot0 : EMPTY_REC;

    assign instr_ready_o   = r_rdy;
    assign dec_valid_o     = (r_occ != 2'd0);
    assign func_o          = w_head.func;
    assign rd_addr_o       = w_head.rd;
    assign rs1_addr_o      = w_head.rs1;
    assign rs2_addr_o      = w_head.rs2;
    assign uses_rs2_o      = w_head.uses_rs2;
    assign imm_o           = w_head.imm;
    assign imm_ext_o       = {{(DATA_WIDTH-6){w_head.imm[5]}}, w_head.imm};
    assign illegal_count_o = r_cnt;

endmodule

// File: tb/tb_alu_instr_decoder.sv
// Bench for alu_instr_decoder: queue-based reference model checked every negedge, plus literal expectations.
// Inputs change 1 time unit after posedge; the model advances on posedge and on reset assertion.
// Downstream backpressure is driven from the stimulus through dec_ready_i.
module tb_alu_instr_decoder;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic [15:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic        flush_i = 1'b0;
    simple_processor_pkg::func_t func_o;
    logic [2:0]  rd_addr_o;
    logic [2:0]  rs1_addr_o;
    logic [2:0]  rs2_addr_o;
    logic        uses_rs2_o;
    logic [5:0]  imm_o;
    logic [31:0] imm_ext_o;
    logic        dec_valid_o;
    logic        dec_ready_i = 1'b0;
    logic [7:0]  illegal_count_o;

    int n_checks = 0;
    int n_errors = 0;

    alu_instr_decoder dut (
        .clk_i           (clk_i),
        .arst_i          (arst_i),
        .instr_i         (instr_i),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .flush_i         (flush_i),
        .func_o          (func_o),
        .rd_addr_o       (rd_addr_o),
        .rs1_addr_o      (rs1_addr_o),
        .rs2_addr_o      (rs2_addr_o),
        .uses_rs2_o      (uses_rs2_o),
        .imm_o           (imm_o),
        .imm_ext_o       (imm_ext_o),
        .dec_valid_o     (dec_valid_o),
        .dec_ready_i     (dec_ready_i),
        .illegal_count_o (illegal_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          func;
        int          rd;
        int          rs1;
        int          rs2;
        int          uses;
        int          imm;
        logic [31:0] ext;
    } exp_t;

    function automatic exp_t model_dec(input logic [15:0] ins);
        exp_t e;
        int   op;
        int   v;
        op     = int'(ins) / 4096;
        e.func = (op <= 2) ? op : 3;
        e.rd   = (int'(ins) / 512) % 8;
        e.rs1  = (int'(ins) / 64) % 8;
        e.imm  = int'(ins) % 64;
        if (e.func <= 1) begin
            e.rs2  = (int'(ins) / 8) % 8;
            e.uses = 1;
        end else begin
            e.rs2  = 0;
            e.uses = 0;
        end
        v     = (e.imm >= 32) ? e.imm - 64 : e.imm;
        e.ext = 32'(v);
        return e;
    endfunction

    logic [15:0] m_q[$];
    logic        m_rdy = 1'b0;
    int          m_cnt = 0;

    // Model: buffer is a queue of raw instructions, at most 2 deep.
    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            m_q.delete();
            m_rdy = 1'b0;
            m_cnt = 0;
        end else begin
            logic acc;
            logic pop;
            acc = instr_valid_i && m_rdy;
            pop = (m_q.size() > 0) && dec_ready_i;
            if (acc && (int'(instr_i) / 4096) > 2 && m_cnt < 255) m_cnt++;
            if (flush_i) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (acc) m_q.push_back(instr_i);
            end
            m_rdy = (m_q.size() < 2);
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk_i) begin
        exp_t e;
        if (m_q.size() > 0) begin
            e = model_dec(m_q[0]);
        end else begin
            e = '{func: 3, rd: 0, rs1: 0, rs2: 0, uses: 0, imm: 0, ext: 32'd0};
        end
        check("m_dec_valid", 64'(dec_valid_o), 64'(m_q.size() > 0));
        check("m_ready", 64'(instr_ready_o), 64'(m_rdy));
        check("m_func", 64'(int'(func_o)), 64'(e.func));
        check("m_rd", 64'(rd_addr_o), 64'(e.rd));
        check("m_rs1", 64'(rs1_addr_o), 64'(e.rs1));
        check("m_rs2", 64'(rs2_addr_o), 64'(e.rs2));
        check("m_uses_rs2", 64'(uses_rs2_o), 64'(e.uses));
        check("m_imm", 64'(imm_o), 64'(e.imm));
        check("m_imm_ext", 64'(imm_ext_o), 64'(e.ext));
        check("m_count", 64'(illegal_count_o), 64'(m_cnt));
    end

    // ---------------- stimulus ----------------
    // Drive inputs for one clock edge; returns 1 unit after that edge.
    task automatic cyc(input logic vld, input logic [15:0] ins, input logic drdy, input logic fl);
        instr_valid_i = vld;
        instr_i       = ins;
        dec_ready_i   = drdy;
        flush_i       = fl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_head(input string nm, input int fn, input int rd, input int rs1,
                               input int rs2, input int uses);
        check({nm, "_valid"}, 64'(dec_valid_o), 64'd1);
        check({nm, "_func"}, 64'(int'(func_o)), 64'(fn));
        check({nm, "_rd"}, 64'(rd_addr_o), 64'(rd));
        check({nm, "_rs1"}, 64'(rs1_addr_o), 64'(rs1));
        check({nm, "_rs2"}, 64'(rs2_addr_o), 64'(rs2));
        check({nm, "_uses"}, 64'(uses_rs2_o), 64'(uses));
    endtask

    initial begin
        logic [15:0] w;
        arst_i = 1'b0;
        #1 arst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", 64'(instr_ready_o), 64'd0);
        check("rst_valid", 64'(dec_valid_o), 64'd0);
        check("rst_func", 64'(int'(func_o)), 64'd3);
        check("rst_count", 64'(illegal_count_o), 64'd0);
        #2 arst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("post_rst_ready", 64'(instr_ready_o), 64'd1);

        // single decodes
        cyc(1'b1, 16'h0650, 1'b1, 1'b0);
        expect_head("add", 0, 3, 1, 2, 1);
        cyc(1'b1, 16'h1FA8, 1'b1, 1'b0);
        expect_head("sub", 1, 7, 6, 5, 1);
        cyc(1'b1, 16'h247F, 1'b1, 1'b0);
        expect_head("addi", 2, 2, 1, 0, 0);
        check("addi_imm", 64'(imm_o), 64'h3F);
        check("addi_ext", 64'(imm_ext_o), 64'hFFFF_FFFF);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        check("empty_valid", 64'(dec_valid_o), 64'd0);
        check("empty_func", 64'(int'(func_o)), 64'd3);

        // backpressure
        cyc(1'b1, 16'h0650, 1'b0, 1'b0);
        check("bp1_ready", 64'(instr_ready_o), 64'd1);
        cyc(1'b1, 16'h1FA8, 1'b0, 1'b0);
        check("bp2_ready", 64'(instr_ready_o), 64'd0);
        expect_head("bp2_head", 0, 3, 1, 2, 1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        expect_head("bp_hold", 0, 3, 1, 2, 1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        expect_head("bp_pop", 1, 7, 6, 5, 1);
        check("bp_pop_ready", 64'(instr_ready_o), 64'd1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        check("bp_drained", 64'(dec_valid_o), 64'd0);

        // streaming of legal instructions
        for (int i = 0; i < 100; i++) begin
            w        = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 2));
            cyc(1'b1, w, 1'b1, 1'b0);
        end
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);

        // illegal opcodes
        cyc(1'b1, 16'hF000, 1'b1, 1'b0);
        expect_head("ill_f", 3, 0, 0, 0, 0);
        cyc(1'b1, 16'h3000, 1'b1, 1'b0);
        cyc(1'b1, 16'hA123, 1'b1, 1'b0);
        expect_head("ill_a", 3, 0, 4, 0, 0);
        check("ill_a_imm", 64'(imm_o), 64'h23);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        check("ill_count3", 64'(illegal_count_o), 64'd3);

        // flush with a full buffer and a concurrent valid
        cyc(1'b1, 16'h1FA8, 1'b0, 1'b0);
        cyc(1'b1, 16'h247F, 1'b0, 1'b0);
        check("fl_full_ready", 64'(instr_ready_o), 64'd0);
        cyc(1'b1, 16'h0650, 1'b1, 1'b1);
        check("fl_valid", 64'(dec_valid_o), 64'd0);
        check("fl_ready", 64'(instr_ready_o), 64'd1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        check("fl_no_0650", 64'(dec_valid_o), 64'd0);
        // flushed INVALID still counts
        cyc(1'b1, 16'hF000, 1'b0, 1'b1);
        check("fl_ill_valid", 64'(dec_valid_o), 64'd0);
        check("fl_ill_count", 64'(illegal_count_o), 64'd4);

        // saturation
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 16'(16'h8000 + i), 1'b1, 1'b0);
        end
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        check("sat_count", 64'(illegal_count_o), 64'd255);

        // reset mid-stream with two buffered entries
        cyc(1'b1, 16'h0650, 1'b0, 1'b0);
        cyc(1'b1, 16'h1FA8, 1'b0, 1'b0);
        instr_valid_i = 1'b0;
        #2 arst_i = 1'b1;
        #1;
        check("mrst_valid", 64'(dec_valid_o), 64'd0);
        check("mrst_func", 64'(int'(func_o)), 64'd3);
        check("mrst_rd", 64'(rd_addr_o), 64'd0);
        check("mrst_count", 64'(illegal_count_o), 64'd0);
        check("mrst_ready", 64'(instr_ready_o), 64'd0);
        #2 arst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("mrst_ready_after", 64'(instr_ready_o), 64'd1);
        cyc(1'b1, 16'h247F, 1'b1, 1'b0);
        expect_head("mrst_addi", 2, 2, 1, 0, 0);
        check("mrst_addi_ext", 64'(imm_ext_o), 64'hFFFF_FFFF);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        check("mrst_drained", 64'(dec_valid_o), 64'd0);

        @(negedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_instr_decoder.md
Name: alu_instr_decoder

Overview:
- Decode stage that produces the operand-select controls consumed by alu_math: func_t, register addresses and the 6-bit immediate with sign extension.
- Accepts 16-bit instructions over a valid/ready handshake from fetch.
- Holds up to two decoded instructions in a 2-entry skid buffer, so full throughput is kept under downstream backpressure.
- Counts illegal opcodes for debug.

Parameters:
- INSTR_WIDTH, 16, instruction width; the field map below is fixed for 16.
- DATA_WIDTH, 32 (from simple_processor_pkg), width of imm_ext_o.
- CNT_WIDTH, 8, width of the saturating illegal-instruction counter.

Ports:
- clk_i  input  1  clock; all state changes on posedge.
- arst_i  input  1  asynchronous reset, active-high.
- instr_i  input  INSTR_WIDTH  instruction from fetch.
- instr_valid_i  input  1  instr_i is valid.
- instr_ready_o  output  1  decoder can accept this cycle.
- flush_i  input  1  synchronous discard of all buffered entries.
- func_o  output  func_t  ALU operation (ADD, SUB, ADDI, INVALID).
- rd_addr_o  output  3  destination register.
- rs1_addr_o  output  3  source register 1.
- rs2_addr_o  output  3  source register 2; 0 for ADDI/INVALID.
- uses_rs2_o  output  1  1 for ADD/SUB only.
- imm_o  output  6  raw immediate instr[5:0].
- imm_ext_o  output  DATA_WIDTH  {{26{imm[5]}}, imm}.
- dec_valid_o  output  1  head entry valid.
- dec_ready_i  input  1  downstream accepts head entry.
- illegal_count_o  output  CNT_WIDTH  accepted INVALID opcodes, saturating.

Behaviour:
- Field map:
  - opcode = instr[15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm = [5:0].
  - Opcode 0 → ADD, 1 → SUB, 2 → ADDI, all others → INVALID.
- Accept and pop:
  - Accept occurs when instr_valid_i && instr_ready_o.
  - Pop occurs when dec_valid_o && dec_ready_i.
- Buffer:
  - 2-entry in-order FIFO of fully decoded records; decode happens before the register, so all outputs are registered.
  - Occupancy 0..2. instr_ready_o = (occupancy < 2), driven from registered state only, with no combinational path from dec_ready_i.
  - dec_valid_o = (occupancy > 0).
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 if the buffer was empty; otherwise it appears behind the older entry.
- Occupancy updates:
  - Accept with no pop: +1.
  - Pop with no accept: −1.
  - Accept and pop together: unchanged. The head advances and the new entry is written behind it. When occupancy = 1, the new entry becomes head the next cycle.
  - Occupancy = 2: instr_ready_o = 0, so no accept is possible; a pop drops occupancy to 1.
- Stability: while dec_valid_o && !dec_ready_i, all decoded outputs hold stable.
- Empty buffer (dec_valid_o = 0): outputs are driven to func_o = INVALID and all address/imm fields = 0, so the state is deterministic.
- INVALID opcodes are still enqueued and delivered (downstream decides to trap). illegal_count_o increments on accept of an INVALID opcode and saturates at 2^CNT_WIDTH−1.
- ADDI and INVALID force rs2_addr_o = 0 and uses_rs2_o = 0. The imm fields are always driven from instr[5:0] for every opcode.
- flush_i:
  - Next cycle occupancy = 0 and dec_valid_o = 0.
  - Flush wins over a simultaneous accept: that instruction is dropped but still counts toward illegal_count_o if INVALID.
  - Flush wins over a simultaneous pop: the pop is still a completed transfer for downstream.
  - The counter is not cleared by flush.
- Reset (arst_i = 1, asynchronous, any time including mid-transfer):
  - occupancy = 0, dec_valid_o = 0, instr_ready_o = 0 while arst_i is asserted and 1 from the first clock after deassertion.
  - func_o = INVALID, all fields = 0, illegal_count_o = 0.

Test Plan:
- Single decode, no backpressure:
  - instr 0x0650 → next cycle ADD, rd = 3, rs1 = 1, rs2 = 2, uses_rs2 = 1.
  - instr 0x1FA8 → SUB, rd = 7, rs1 = 6, rs2 = 5.
  - instr 0x247F → ADDI, rd = 2, rs1 = 1, rs2 = 0, imm_o = 0x3F, imm_ext_o = 0xFFFFFFFF.
- Backpressure: hold dec_ready_i = 0, push 0x0650 then 0x1FA8 → instr_ready_o = 0 after the second accept and head stays ADD. Then raise dec_ready_i → ADD then SUB in consecutive cycles, and instr_ready_o = 1 one cycle after the first pop.
- Streaming: valid and ready held high for 100 random legal instructions → one output per cycle, in order, 1-cycle latency, no bubbles. Compare func/imm_ext against alu_math operand semantics.
- Illegal: 0xF000, 0x3000, 0xA123 → delivered as INVALID with rs2 = 0, illegal_count_o = 3. Then 300 INVALIDs → count saturates at 255.
- Flush: buffer full (2 entries) plus flush_i with a concurrent valid 0x0650 → next cycle dec_valid_o = 0, occupancy 0, and 0x0650 never appears.
- Reset mid-stream: assert arst_i between clock edges with 2 entries buffered → outputs immediately INVALID/0, dec_valid_o = 0, illegal_count_o = 0. After release, decoding resumes correctly from the first new instruction.
